fifo_rd_port: RTL and testbench

Read-side controller for the asynchronous FIFO. It lives entirely in the read clock domain and drives the read port of the dual-clock FIFO memory (read enable, read address, registered read data). It computes empty from the synchronized write pointer and exports the Gray-coded read pointer for the write domain. It hides the memory's one-cycle read latency behind a 2-entry prefetch buffer, so the consumer sees a first-word-fall-through valid/ready stream at full throughput.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_rd_prefetch_buf.sv | 88 ++++++++
 rtl/fifo_rd_port.sv | 142 ++++++++++++++
 tb/tb_fifo_rd_port.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared definitions for the dual-clock FIFO controllers.
//                Holds the Gray/binary pointer conversion helpers and the
//                depth of the read-side prefetch buffer. Used by both the
//                read-side and the write-side controllers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Number of entries in the read-side prefetch buffer. One entry covers
    // the word in flight from the memory, the other covers the head word
    // the consumer is looking at, which is what keeps full throughput.
    localparam int FIFO_RD_BUF_DEPTH = 2;

    // Conversions work on a 32-bit container. Callers zero-extend their
    // pointer in and truncate the result back to the pointer width; the
    // zero upper bits make both conversions exact for any narrower width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_prefetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_prefetch_buf
//  Description : Small in-order buffer (FIFO_RD_BUF_DEPTH entries) that
//                collects words returned by the FIFO memory and presents the
//                oldest one as the head of a first-word-fall-through stream.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_clk      in   clock (read domain)
//    i_rst      in   synchronous active-high reset; clears entries and count
//    i_push     in   write i_push_data at the tail this cycle
//    i_push_data in  word to append
//    i_pop      in   drop the head word this cycle
//    o_occ      out  number of stored words (0..FIFO_RD_BUF_DEPTH)
//    o_valid    out  at least one word stored
//    o_head     out  oldest stored word
// ============================================================================
module fifo_rd_prefetch_buf
    import fifo_pkg::*;
#(
    parameter int SIZE_DATA = 8
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst,
    input  logic                                           i_push,
    input  logic [SIZE_DATA-1:0]                           i_push_data,
    input  logic                                           i_pop,
    output logic [$clog2(FIFO_RD_BUF_DEPTH+1)-1:0]         o_occ,
    output logic                                           o_valid,
    output logic [SIZE_DATA-1:0]                           o_head
);

    localparam int c_OCC_W = $clog2(FIFO_RD_BUF_DEPTH + 1);
    localparam int c_IDX_W = $clog2(FIFO_RD_BUF_DEPTH);

    logic [SIZE_DATA-1:0] buf_q [FIFO_RD_BUF_DEPTH];
    logic [SIZE_DATA-1:0] buf_d [FIFO_RD_BUF_DEPTH];
    logic [c_IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_OCC_W-1:0]   occ_q, occ_d;

    // Pointers wrap naturally at the index width, which relies on the
    // buffer depth being a power of two.
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (i_push) begin
            buf_d[wr_ptr_q] = i_push_data;
            wr_ptr_d        = wr_ptr_q + c_IDX_W'(1);
        end
        if (i_pop) begin
            rd_ptr_d = rd_ptr_q + c_IDX_W'(1);
        end

        // A simultaneous push and pop leaves the count unchanged.
        case ({i_push, i_pop})
            2'b10:   occ_d = occ_q + c_OCC_W'(1);
            2'b01:   occ_d = occ_q - c_OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_RD_BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign o_occ   = occ_q;
    assign o_valid = (occ_q != '0);
    assign o_head  = buf_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_port.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_port
//  Description : Read-side controller of the asynchronous FIFO. Runs in the
//                read clock domain, drives the memory read port, derives
//                empty from the synchronized write pointer, exports the
//                Gray-coded read pointer and hides the memory's one-cycle
//                read latency behind a 2-entry prefetch buffer, giving a
//                full-throughput first-word-fall-through valid/ready stream.
//  Revision    : 1.0 - initial release
//
//  Build option
//    FIFO_RD_LEVEL_EN  when defined, adds o_rd_level (words visible to the
//                      reader: unread memory words + buffered + in flight)
//
//  Ports
//    i_clk               in   read-domain clock
//    i_rst               in   synchronous active-high reset
//    i_wr_ptr_gray_sync  in   write pointer, Gray, synchronized to i_clk
//    o_rd_ptr_gray       out  read pointer, Gray, registered
//    o_mem_rd_en         out  memory read enable
//    o_mem_addr_rd       out  memory read address
//    i_mem_data_rd       in   memory registered read data
//    o_valid             out  head word present
//    o_data              out  head word
//    i_ready             in   consumer accepts the head word
//    o_empty             out  no unread word left in memory
//    o_rd_level          out  words visible to the reader (option only)
// ============================================================================
module fifo_rd_port
    import fifo_pkg::*;
#(
    parameter int SIZE_DATA  = 8,
    parameter int SIZE_DEPTH = 16,
    parameter int SIZE_ADDR  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [SIZE_ADDR:0]     i_wr_ptr_gray_sync,
    output logic [SIZE_ADDR:0]     o_rd_ptr_gray,
    output logic                   o_mem_rd_en,
    output logic [SIZE_ADDR-1:0]   o_mem_addr_rd,
    input  logic [SIZE_DATA-1:0]   i_mem_data_rd,
    output logic                   o_valid,
    output logic [SIZE_DATA-1:0]   o_data,
    input  logic                   i_ready,
    output logic                   o_empty
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [SIZE_ADDR+1:0]   o_rd_level
`endif
);

    localparam int c_PTR_W  = SIZE_ADDR + 1;
    localparam int c_OCC_W  = $clog2(FIFO_RD_BUF_DEPTH + 1);
    localparam int c_PEND_W = c_OCC_W + 1;

    // The pointer arithmetic assumes the memory depth is exactly 2**SIZE_ADDR.
    if (SIZE_DEPTH != (1 << SIZE_ADDR)) begin : g_depth_check
        $error("fifo_rd_port: SIZE_DEPTH must equal 2**SIZE_ADDR");
    end

    logic [c_PTR_W-1:0]  rd_bin_q, rd_bin_d;
    logic [c_PTR_W-1:0]  rd_gray_q, rd_gray_d;
    logic                inflight_q, inflight_d;

    logic [c_OCC_W-1:0]  w_occ;
    logic                w_valid;
    logic                w_pop;
    logic                w_empty;
    logic                w_issue;
    logic [c_PEND_W-1:0] w_pending;

    // Pointers are equal including the wrap bit only when nothing is unread.
    assign w_empty = (rd_gray_q == i_wr_ptr_gray_sync);
    assign w_pop   = w_valid & i_ready;

    // Words the buffer will hold after this edge if no new read is issued.
    // pop implies occ >= 1, so this never underflows.
    assign w_pending = c_PEND_W'(w_occ) + c_PEND_W'(inflight_q) - c_PEND_W'(w_pop);

    // Issuing only while fewer than FIFO_RD_BUF_DEPTH words are pending
    // guarantees the buffer has room when the read data returns.
    assign w_issue = !w_empty && (w_pending < c_PEND_W'(FIFO_RD_BUF_DEPTH));

    always_comb begin
        rd_bin_d = rd_bin_q;
        if (w_issue) begin
            rd_bin_d = rd_bin_q + c_PTR_W'(1);
        end
        // Registering the Gray form of the next pointer keeps the exported
        // pointer glitch-free and in step with rd_bin.
        rd_gray_d  = c_PTR_W'(bin2gray(32'(rd_bin_d)));
        inflight_d = w_issue;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_bin_q   <= '0;
            rd_gray_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            rd_bin_q   <= rd_bin_d;
            rd_gray_q  <= rd_gray_d;
            inflight_q <= inflight_d;
        end
    end

    // Data of a read issued last cycle is valid now and lands at the tail.
    fifo_rd_prefetch_buf #(
        .SIZE_DATA   (SIZE_DATA)
    ) u_prefetch_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (inflight_q),
        .i_push_data (i_mem_data_rd),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_valid     (w_valid),
        .o_head      (o_data)
    );

    assign o_rd_ptr_gray = rd_gray_q;
    assign o_mem_rd_en   = w_issue;
    assign o_mem_addr_rd = rd_bin_q[SIZE_ADDR-1:0];
    assign o_valid       = w_valid;
    assign o_empty       = w_empty;

`ifdef FIFO_RD_LEVEL_EN
    localparam int c_LVL_W = SIZE_ADDR + 2;

    logic [c_PTR_W-1:0] w_wr_bin;
    logic [c_PTR_W-1:0] w_mem_words;

    // Modular difference of the wrap-extended pointers is the unread count.
    assign w_wr_bin    = c_PTR_W'(gray2bin(32'(i_wr_ptr_gray_sync)));
    assign w_mem_words = w_wr_bin - rd_bin_q;
    assign o_rd_level  = c_LVL_W'(w_mem_words) + c_LVL_W'(w_occ) + c_LVL_W'(inflight_q);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_port
//  Description : Self-checking bench for fifo_rd_port. A behavioural
//                registered-read memory stands in for the FIFO RAM and the
//                bench drives the synchronized write pointer directly.
//                Build option FIFO_RD_LEVEL_EN adds the level check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_port;

    logic       clk;
    logic       rst;
    logic [4:0] wr_gray;
    logic [4:0] rd_gray;
    logic       mem_rd_en;
    logic [3:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       empty;
`ifdef FIFO_RD_LEVEL_EN
    logic [5:0] rd_level;
`endif

    logic [7:0] mem [16];

    int n_cmp;
    int n_bad;

    fifo_rd_port #(
        .SIZE_DATA  (8),
        .SIZE_DEPTH (16),
        .SIZE_ADDR  (4)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_wr_ptr_gray_sync (wr_gray),
        .o_rd_ptr_gray      (rd_gray),
        .o_mem_rd_en        (mem_rd_en),
        .o_mem_addr_rd      (mem_addr),
        .i_mem_data_rd      (mem_rd_data),
        .o_valid            (valid),
        .o_data             (data),
        .i_ready            (ready),
        .o_empty            (empty)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .o_rd_level         (rd_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory: one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    function automatic logic [4:0] tb_b2g(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    function automatic logic [4:0] tb_g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [4:0] wr;
        logic       rdy;
        logic       chk;
        logic       v;
        logic [7:0] d;
        logic       en;
        logic [3:0] a;
        logic [4:0] g;
        logic       e;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [4:0] w, logic rd, logic c, logic v,
                                logic [7:0] d, logic en, logic [3:0] a, logic [4:0] g, logic e);
        vec_t x;
        x.rst = r; x.wr = w; x.rdy = rd; x.chk = c; x.v = v;
        x.d = d; x.en = en; x.a = a; x.g = g; x.e = e;
        return x;
    endfunction

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1; wr_gray = '0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int         written;
        int         received;
        int         cyc;
        logic [4:0] wr_bin;
        logic [4:0] prev_gray;
        logic [4:0] diff;
        logic [7:0] d;
        logic [7:0] q[$];
        bit         wrapped;
        bit         seen;

        n_cmp = 0; n_bad = 0;
        rst = 1'b1; wr_gray = '0; ready = 1'b0; mem_rd_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);

        // ---------------- table: reset, fall-through, stall ----------------
        //           rst wr  rdy chk v  data   en a  g  e
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(0, 6, 1, 1, 0, 8'h00, 1, 0, 0, 0));
        vecs.push_back(mk(0, 6, 1, 1, 0, 8'h00, 1, 1, 1, 0));
        vecs.push_back(mk(0, 6, 1, 1, 1, 8'hA0, 1, 2, 3, 0));
        vecs.push_back(mk(0, 6, 1, 1, 1, 8'hA1, 1, 3, 2, 0));
        vecs.push_back(mk(0, 6, 1, 1, 1, 8'hA2, 0, 4, 6, 1));
        vecs.push_back(mk(0, 6, 1, 1, 1, 8'hA3, 0, 4, 6, 1));
        vecs.push_back(mk(0, 6, 1, 1, 0, 8'h00, 0, 4, 6, 1));
        // re-reset, then the same preload with the consumer stalled
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(0, 6, 0, 1, 0, 8'h00, 1, 0, 0, 0));
        vecs.push_back(mk(0, 6, 0, 1, 0, 8'h00, 1, 1, 1, 0));
        vecs.push_back(mk(0, 6, 0, 1, 1, 8'hA0, 0, 2, 3, 0));
        vecs.push_back(mk(0, 6, 0, 1, 1, 8'hA0, 0, 2, 3, 0));
        vecs.push_back(mk(0, 6, 0, 1, 1, 8'hA0, 0, 2, 3, 0));
        vecs.push_back(mk(0, 6, 1, 1, 1, 8'hA0, 1, 2, 3, 0));
        vecs.push_back(mk(0, 6, 1, 1, 1, 8'hA1, 1, 3, 2, 0));
        vecs.push_back(mk(0, 6, 1, 1, 1, 8'hA2, 0, 4, 6, 1));
        vecs.push_back(mk(0, 6, 1, 1, 1, 8'hA3, 0, 4, 6, 1));
        vecs.push_back(mk(0, 6, 1, 1, 0, 8'h00, 0, 4, 6, 1));

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst = vecs[i].rst; wr_gray = vecs[i].wr; ready = vecs[i].rdy;
            @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("row%0d valid", i), 32'(valid), 32'(vecs[i].v));
                if (vecs[i].v || vecs[i].rst)
                    check($sformatf("row%0d data", i), 32'(data), 32'(vecs[i].d));
                check($sformatf("row%0d rd_en", i), 32'(mem_rd_en), 32'(vecs[i].en));
                check($sformatf("row%0d addr", i), 32'(mem_addr), 32'(vecs[i].a));
                check($sformatf("row%0d rd_gray", i), 32'(rd_gray), 32'(vecs[i].g));
                check($sformatf("row%0d empty", i), 32'(empty), 32'(vecs[i].e));
            end
        end

        // ---------------- 40 words, random consumer, pointer wrap ----------
        reset_dut();
        written = 0; received = 0; wr_bin = '0; prev_gray = '0; wrapped = 0;
        for (cyc = 0; cyc < 2000 && received < 40; cyc++) begin
            @(posedge clk); #1;
            diff = wr_bin - tb_g2b(rd_gray);
            if (written < 40 && diff < 5'd16) begin
                d = 8'(written * 37 + 11);
                mem[wr_bin[3:0]] = d;
                q.push_back(d);
                wr_bin  = wr_bin + 5'd1;
                wr_gray = tb_b2g(wr_bin);
                written++;
            end
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (valid && ready) begin
                if (q.size() == 0) check("stream extra word", 32'(data), 32'hFFFF_FFFF);
                else check($sformatf("stream word %0d", received), 32'(data), 32'(q.pop_front()));
                received++;
            end
            if (rd_gray != prev_gray) begin
                check("gray one-bit step", 32'($countones(rd_gray ^ prev_gray)), 32'd1);
                if (prev_gray == 5'b10000 && rd_gray == 5'b00000) wrapped = 1;
                prev_gray = rd_gray;
            end
        end
        check("stream words received", 32'(received), 32'd40);
        check("pointer wrapped", 32'(wrapped), 32'd1);
        check("final rd_gray", 32'(rd_gray), 32'(5'b01100));
        @(posedge clk); #1 ready = 1'b1;
        @(negedge clk);
        check("final empty", 32'(empty), 32'd1);
        check("final valid", 32'(valid), 32'd0);

        // ---------------- reset mid-operation ------------------------------
        reset_dut();
        for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
        @(posedge clk); #1 wr_gray = 5'd6; ready = 1'b0;
        repeat (4) @(posedge clk);
        // buffer is full; release the consumer and reset on the same edge
        #1 ready = 1'b1; rst = 1'b1; wr_gray = '0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst valid", 32'(valid), 32'd0);
        check("midrst rd_gray", 32'(rd_gray), 32'd0);
        check("midrst addr", 32'(mem_addr), 32'd0);
        check("midrst rd_en", 32'(mem_rd_en), 32'd0);
        check("midrst empty", 32'(empty), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        check("midrst no stale word", 32'(seen), 32'd0);
        @(posedge clk); #1 mem[0] = 8'h5A; wr_gray = tb_b2g(5'd1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        check("midrst new word arrives", 32'(seen), 32'd1);
        check("midrst new word data", 32'(data), 32'h5A);

`ifdef FIFO_RD_LEVEL_EN
        // ---------------- level: 5 written, 2 popped -----------------------
        reset_dut();
        for (int i = 0; i < 5; i++) mem[i] = 8'hC0 + 8'(i);
        @(posedge clk); #1 wr_gray = tb_b2g(5'd5);
        for (int p = 0; p < 2; p++) begin
            seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (valid) seen = 1;
            end
            check($sformatf("level pop %0d ready", p), 32'(seen), 32'd1);
            ready = 1'b1;
            @(posedge clk); #1 ready = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rd_level after 5 in 2 out", 32'(rd_level), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
